// File: rtl/lane_occupancy_counter_if.sv
// Pin-side bundle for the lane occupancy counter: raw laser/button inputs and
// count/flag/event outputs toward the display driver.
interface lane_occupancy_counter_if #(
    parameter int N_LANES = 2,
    parameter int CNT_W   = 7
);
    logic                   i_button;
    logic [2*N_LANES-1:0]   i_lasers;
    logic [CNT_W-1:0]       o_count;
    logic                   o_full;
    logic                   o_empty;
    logic [N_LANES-1:0]     o_enter_p;
    logic [N_LANES-1:0]     o_exit_p;
    logic [N_LANES-1:0]     o_seq_err;
    logic                   o_overflow;
    logic                   o_underflow;

    modport master (
        output i_button, i_lasers,
        input  o_count, o_full, o_empty, o_enter_p, o_exit_p, o_seq_err,
               o_overflow, o_underflow
    );

    modport slave (
        input  i_button, i_lasers,
        output o_count, o_full, o_empty, o_enter_p, o_exit_p, o_seq_err,
               o_overflow, o_underflow
    );
endinterface

// File: rtl/lane_occupancy_counter.sv
// N_LANES laser-pair direction FSMs feeding one shared saturating occupancy
// counter with a synchronised push-button clear.

module lane_occupancy_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_beams,   // {B inner, A outer}, already synchronised
    output logic       o_enter,
    output logic       o_exit,
    output logic       o_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_IN1, S_IN2, S_IN3, S_OUT1, S_OUT2, S_OUT3
    } state_t;

    state_t r_state, w_next;
    logic   w_enter, w_exit, w_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            o_enter <= 1'b0;
            o_exit  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            o_enter <= w_enter;
            o_exit  <= w_exit;
            o_err   <= w_err;
        end
    end

    // Any beam code not listed for a state is "unchanged" and holds the state.
    always_comb begin
        w_next  = r_state;
        w_enter = 1'b0;
        w_exit  = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            S_IDLE: case (i_beams)
                2'b01:   w_next = S_IN1;
                2'b10:   w_next = S_OUT1;
                2'b11:   w_err  = 1'b1;
                default: ;
            endcase
            S_IN1: case (i_beams)
                2'b11:   w_next = S_IN2;
                2'b00:   w_next = S_IDLE;
                2'b10:   begin w_next = S_IDLE; w_err = 1'b1; end
                default: ;
            endcase
            S_IN2: case (i_beams)
                2'b10:   w_next = S_IN3;
                2'b01:   w_next = S_IN1;
                2'b00:   begin w_next = S_IDLE; w_err = 1'b1; end
                default: ;
            endcase
            S_IN3: case (i_beams)
                2'b00:   begin w_next = S_IDLE; w_enter = 1'b1; end
                2'b11:   w_next = S_IN2;
                2'b01:   begin w_next = S_IDLE; w_err = 1'b1; end
                default: ;
            endcase
            S_OUT1: case (i_beams)
                2'b11:   w_next = S_OUT2;
                2'b00:   w_next = S_IDLE;
                2'b01:   begin w_next = S_IDLE; w_err = 1'b1; end
                default: ;
            endcase
            S_OUT2: case (i_beams)
                2'b01:   w_next = S_OUT3;
                2'b10:   w_next = S_OUT1;
                2'b00:   begin w_next = S_IDLE; w_err = 1'b1; end
                default: ;
            endcase
            S_OUT3: case (i_beams)
                2'b00:   begin w_next = S_IDLE; w_exit = 1'b1; end
                2'b11:   w_next = S_OUT2;
                2'b10:   begin w_next = S_IDLE; w_err = 1'b1; end
                default: ;
            endcase
            default: w_next = S_IDLE;
        endcase
    end
endmodule

module lane_occupancy_counter #(
    parameter int N_LANES  = 2,
    parameter int CAPACITY = 99
) (
    input  logic                     clk,
    input  logic                     rst,
    lane_occupancy_counter_if.slave  bus
);
    localparam int CNT_W = $clog2(CAPACITY + 1);
    localparam int SW    = CNT_W + $clog2(N_LANES) + 2;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    logic [2*N_LANES-1:0] r_las_s1, r_las_s2;
    logic                 r_btn_s1, r_btn_s2, r_btn_d;
    logic [N_LANES-1:0]   w_enter, w_exit, w_err;
    logic [CNT_W-1:0]     r_count;
    logic                 r_ovf, r_unf;
    logic                 w_clr;
    logic signed [SW-1:0] w_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_las_s1 <= '0;
            r_las_s2 <= '0;
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_btn_d  <= 1'b0;
        end else begin
            r_las_s1 <= bus.i_lasers;
            r_las_s2 <= r_las_s1;
            r_btn_s1 <= bus.i_button;
            r_btn_s2 <= r_btn_s1;
            r_btn_d  <= r_btn_s2;
        end
    end

    assign w_clr = r_btn_s2 & ~r_btn_d;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        lane_occupancy_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_beams (r_las_s2[2*g+1:2*g]),
            .o_enter (w_enter[g]),
            .o_exit  (w_exit[g]),
            .o_err   (w_err[g])
        );
    end

    // Entries and exits from all lanes net out before the clamp is applied.
    always_comb begin
        w_sum = $signed({{(SW-CNT_W){1'b0}}, r_count});
        for (int i = 0; i < N_LANES; i++) begin
            w_sum = w_sum + SW'(w_enter[i]) - SW'(w_exit[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (w_clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (w_sum > CAP_S) begin
            r_count <= CNT_W'(CAPACITY);
            r_ovf   <= 1'b1;
            r_unf   <= 1'b0;
        end else if (w_sum < 0) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b1;
        end else begin
            r_count <= w_sum[CNT_W-1:0];
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end
    end

    assign bus.o_count     = r_count;
    assign bus.o_full      = (r_count == CNT_W'(CAPACITY));
    assign bus.o_empty     = (r_count == '0);
    assign bus.o_enter_p   = w_enter;
    assign bus.o_exit_p    = w_exit;
    assign bus.o_seq_err   = w_err;
    assign bus.o_overflow  = r_ovf;
    assign bus.o_underflow = r_unf;
endmodule

// File: tb/tb_lane_occupancy_counter.sv
// Bench for lane_occupancy_counter: scenario tasks plus an event scoreboard
// that matches every observed pulse against the expected queue.
module tb_lane_occupancy_counter;
    localparam int N   = 2;
    localparam int CAP = 3;
    localparam int CW  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lane_occupancy_counter_if #(.N_LANES(N), .CNT_W(CW)) bus ();
    lane_occupancy_counter #(.N_LANES(N), .CAPACITY(CAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    int         exp_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_obs, mon_exp;

    // Event vector layout: {underflow, overflow, seq_err[1:0], exit_p[1:0], enter_p[1:0]}
    always @(negedge clk) begin
        mon_obs = {bus.o_underflow, bus.o_overflow, bus.o_seq_err, bus.o_exit_p, bus.o_enter_p};
        if (mon_obs != 8'h00) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL event_unexpected: got %b, required no event", mon_obs);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_obs !== mon_exp) begin
                    n_fail++;
                    $display("FAIL event_match: got %b, required %b", mon_obs, mon_exp);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input logic [1:0] p);
        bus.i_lasers[2*lane +: 2] = p;
    endtask

    function automatic int pc2(input logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    task automatic push_ev(input logic [1:0] en, input logic [1:0] ex);
        int n;
        n = exp_cnt + pc2(en) - pc2(ex);
        exp_q.push_back({4'b0000, ex, en});
        if (n > CAP) begin
            exp_cnt = CAP;
            exp_q.push_back(8'b0100_0000);
        end else if (n < 0) begin
            exp_cnt = 0;
            exp_q.push_back(8'b1000_0000);
        end else begin
            exp_cnt = n;
        end
    endtask

    // Full pass through one lane; 3 cycles per beam pattern, then settle.
    task automatic pass(input int lane, input bit is_enter);
        logic [1:0] en, ex;
        en = is_enter ? 2'(1 << lane) : 2'b00;
        ex = is_enter ? 2'b00 : 2'(1 << lane);
        set_lane(lane, is_enter ? 2'b01 : 2'b10); cycles(3);
        set_lane(lane, 2'b11);                    cycles(3);
        set_lane(lane, is_enter ? 2'b10 : 2'b01); cycles(3);
        push_ev(en, ex);
        set_lane(lane, 2'b00);                    cycles(5);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1;
        n_chk++; if (bus.o_count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", bus.o_count); end
        n_chk++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b, required 1", bus.o_empty); end
        n_chk++; if (bus.o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b, required 0", bus.o_full); end
        n_chk++; if ({bus.o_enter_p, bus.o_exit_p, bus.o_seq_err} !== 6'd0) begin
            n_fail++; $display("FAIL reset_pulses: got %b, required 0", {bus.o_enter_p, bus.o_exit_p, bus.o_seq_err}); end
        n_chk++; if ({bus.o_overflow, bus.o_underflow} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: got %b, required 00", {bus.o_overflow, bus.o_underflow}); end
        cycles(3);
        rst = 1'b1;
        cycles(2);
    endtask

    task automatic test_entry_latency;
        set_lane(0, 2'b01); cycles(3);
        set_lane(0, 2'b11); cycles(3);
        set_lane(0, 2'b10); cycles(3);
        push_ev(2'b01, 2'b00);
        set_lane(0, 2'b00);
        cycles(2);
        n_chk++; if (bus.o_enter_p !== 2'b00) begin n_fail++; $display("FAIL enter_early: got %b, required 00", bus.o_enter_p); end
        cycles(1);
        n_chk++; if (bus.o_enter_p !== 2'b01) begin n_fail++; $display("FAIL enter_pulse: got %b, required 01", bus.o_enter_p); end
        n_chk++; if (bus.o_count !== 2'd0) begin n_fail++; $display("FAIL count_before_e3: got %0d, required 0", bus.o_count); end
        cycles(1);
        n_chk++; if (bus.o_count !== 2'd1) begin n_fail++; $display("FAIL count_after_entry: got %0d, required 1", bus.o_count); end
        n_chk++; if (bus.o_enter_p !== 2'b00) begin n_fail++; $display("FAIL enter_one_cycle: got %b, required 00", bus.o_enter_p); end
        cycles(3);
    endtask

    task automatic test_exit_underflow;
        pass(0, 1'b0);
        n_chk++; if (bus.o_count !== CW'(exp_cnt)) begin n_fail++; $display("FAIL exit_count: got %0d, required %0d", bus.o_count, exp_cnt); end
        n_chk++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL exit_empty: got %b, required 1", bus.o_empty); end
        pass(0, 1'b0);
        n_chk++; if (bus.o_count !== CW'(exp_cnt)) begin n_fail++; $display("FAIL underflow_count: got %0d, required %0d", bus.o_count, exp_cnt); end
    endtask

    task automatic test_reverse_abort;
        set_lane(0, 2'b01); cycles(3);
        set_lane(0, 2'b11); cycles(3);
        set_lane(0, 2'b01); cycles(3);
        set_lane(0, 2'b00); cycles(5);
        n_chk++; if (bus.o_count !== CW'(exp_cnt)) begin n_fail++; $display("FAIL reverse_count: got %0d, required %0d", bus.o_count, exp_cnt); end
        exp_q.push_back(8'b0001_0000);
        set_lane(0, 2'b11); cycles(1);
        set_lane(0, 2'b00); cycles(6);
        n_chk++; if (bus.o_count !== CW'(exp_cnt)) begin n_fail++; $display("FAIL seqerr_count: got %0d, required %0d", bus.o_count, exp_cnt); end
    endtask

    task automatic test_capacity;
        pass(0, 1'b1);
        pass(1, 1'b1);
        pass(0, 1'b1);
        n_chk++; if (bus.o_full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b, required 1", bus.o_full); end
        n_chk++; if (bus.o_count !== 2'd3) begin n_fail++; $display("FAIL full_count: got %0d, required 3", bus.o_count); end
        pass(1, 1'b1);
        n_chk++; if (bus.o_count !== CW'(exp_cnt)) begin n_fail++; $display("FAIL overflow_count: got %0d, required %0d", bus.o_count, exp_cnt); end
        // Lane 0 enters while lane 1 exits in lock-step.
        set_lane(0, 2'b01); set_lane(1, 2'b10); cycles(3);
        set_lane(0, 2'b11); set_lane(1, 2'b11); cycles(3);
        set_lane(0, 2'b10); set_lane(1, 2'b01); cycles(3);
        push_ev(2'b01, 2'b10);
        set_lane(0, 2'b00); set_lane(1, 2'b00); cycles(5);
        n_chk++; if (bus.o_count !== CW'(exp_cnt)) begin n_fail++; $display("FAIL net_count: got %0d, required %0d", bus.o_count, exp_cnt); end
    endtask

    task automatic test_clear;
        pass(1, 1'b0);
        n_chk++; if (bus.o_count !== 2'd2) begin n_fail++; $display("FAIL preclear_count: got %0d, required 2", bus.o_count); end
        bus.i_button = 1'b1; cycles(1);
        bus.i_button = 1'b0; cycles(1);
        bus.i_button = 1'b1; cycles(1);
        bus.i_button = 1'b0; cycles(1);
        bus.i_button = 1'b1; cycles(20);
        bus.i_button = 1'b0; cycles(3);
        exp_cnt = 0;
        n_chk++; if (bus.o_count !== 2'd0) begin n_fail++; $display("FAIL clear_count: got %0d, required 0", bus.o_count); end
        n_chk++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL clear_empty: got %b, required 1", bus.o_empty); end
        pass(0, 1'b1);
        // Button rise lands in the same cycle as the enter pulse.
        set_lane(0, 2'b01); cycles(3);
        set_lane(0, 2'b11); cycles(3);
        set_lane(0, 2'b10); cycles(3);
        push_ev(2'b01, 2'b00);
        set_lane(0, 2'b00); cycles(1);
        bus.i_button = 1'b1; cycles(5);
        exp_cnt = 0;
        n_chk++; if (bus.o_count !== 2'd0) begin n_fail++; $display("FAIL clear_beats_enter: got %0d, required 0", bus.o_count); end
        bus.i_button = 1'b0; cycles(3);
    endtask

    task automatic test_reset_mid;
        pass(0, 1'b1);
        n_chk++; if (bus.o_count !== 2'd1) begin n_fail++; $display("FAIL premid_count: got %0d, required 1", bus.o_count); end
        set_lane(0, 2'b01); cycles(3);
        set_lane(0, 2'b11); cycles(3);
        rst = 1'b0;
        #1;
        n_chk++; if (bus.o_count !== 2'd0) begin n_fail++; $display("FAIL midrst_count: got %0d, required 0", bus.o_count); end
        n_chk++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty: got %b, required 1", bus.o_empty); end
        exp_cnt = 0;
        set_lane(0, 2'b10);
        cycles(2);
        rst = 1'b1;
        cycles(3);
        set_lane(0, 2'b00); cycles(6);
        n_chk++; if (bus.o_count !== 2'd0) begin n_fail++; $display("FAIL trailing_count: got %0d, required 0", bus.o_count); end
    endtask

    initial begin
        rst          = 1'b1;
        bus.i_button = 1'b0;
        bus.i_lasers = '0;
        #2;
        test_reset();
        test_entry_latency();
        test_exit_underflow();
        test_reverse_abort();
        test_capacity();
        test_clear();
        test_reset_mid();
        cycles(4);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL events_missing: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
